instr_fetch_unit: RTL

- Instruction supplier for the cpu core. Drives the core's i_instr_ready, i_opcode, i_data1 and i_data2 inputs, and observes the core's o_wait.
- Reads fixed-length 3-byte instructions (opcode, data1, data2) from a byte-wide instruction memory. Uses a req/valid handshake with one access outstanding at a time.
- Maintains the program counter, and supports redirect (jump) and halt.

---
 rtl/instr_fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: assembles 3-byte instructions (opcode, data1, data2)
// from a byte-wide memory using a single-outstanding req/valid handshake and
// presents them to the cpu core. Supports redirect (jump) and halt.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [7:0]        i_imem_data,
    output logic              o_instr_ready,
    output logic [7:0]        o_opcode,
    output logic [7:0]        o_data1,
    output logic [7:0]        o_data2,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_cpu_wait,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    input  logic              i_halt
);

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        PRESENT,
        FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        data1_q, data1_d;
    logic [7:0]        data2_q, data2_d;
    logic [ADDR_W-1:0] pcOut_q, pcOut_d;

    logic              beat;
    logic              accept;
    logic [ADDR_W-1:0] pcInc;

    assign beat   = req_q && i_imem_valid;
    assign accept = ready_q && !i_cpu_wait;
    assign pcInc  = pc_q + ADDR_W'(1);

    // Next-state logic: redirect overrides everything; a pending request is never withdrawn.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ready_d  = ready_q;
        opcode_d = opcode_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        pcOut_d  = pcOut_q;

        if (i_redirect) begin
            pc_d    = i_redirect_addr;
            ready_d = 1'b0;
            if (req_q && !i_imem_valid) begin
                state_d = FLUSH;
            end else begin
                state_d = FETCH0;
                req_d   = !i_halt;
                addr_d  = i_redirect_addr;
            end
        end else begin
            case (state_q)
                FETCH0, FETCH1, FETCH2: begin
                    if (beat) begin
                        pc_d = pcInc;
                        case (state_q)
                            FETCH0: begin
                                opcode_d = i_imem_data;
                                pcOut_d  = pc_q;
                                state_d  = FETCH1;
                            end
                            FETCH1: begin
                                data1_d = i_imem_data;
                                state_d = FETCH2;
                            end
                            default: begin
                                data2_d = i_imem_data;
                                state_d = PRESENT;
                            end
                        endcase
                        if (state_q == FETCH2) begin
                            req_d   = 1'b0;
                            ready_d = 1'b1;
                        end else begin
                            req_d = !i_halt;
                        end
                        addr_d = pcInc;
                    end else if (!req_q) begin
                        req_d  = !i_halt;
                        addr_d = pc_q;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        ready_d = 1'b0;
                        state_d = FETCH0;
                        req_d   = !i_halt;
                        addr_d  = pc_q;
                    end
                end
                FLUSH: begin
                    if (beat) begin
                        state_d = FETCH0;
                        req_d   = !i_halt;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = FETCH0;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FETCH0;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            ready_q  <= 1'b0;
            opcode_q <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            pcOut_q  <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            opcode_q <= opcode_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            pcOut_q  <= pcOut_d;
        end
    end

    assign o_imem_req    = req_q;
    assign o_imem_addr   = addr_q;
    assign o_instr_ready = ready_q;
    assign o_opcode      = opcode_q;
    assign o_data1       = data1_q;
    assign o_data2       = data2_q;
    assign o_pc          = pcOut_q;

endmodule
